mpei_spi_slave: RTL and testbench
=================================

# mpei_spi_slave

SPI target (responder) for the MPEI RV MCU: the opposite end of the SPI controller on the top-level SPI port, so the MCU can be driven by an external SPI master. It oversamples SCK, CS_n and MOSI in the system clock domain. It deserialises received frames into a valid/ready RX port and serialises TX data supplied on a valid/ready TX port. The block sits beside the SPI controller on the peripheral bus; a thin register wrapper, outside this block, connects its ports to the bus.

## Interface
Parameters:
- DW, 8: frame width in bits (4..32).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- DUMMY, '1 (all ones): word shifted out when no TX data is available.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- spi_sck_i  in  1  SPI clock from the master; asynchronous to clk_i.
- spi_csn_i  in  1  chip select, active low; asynchronous.
- spi_mosi_i  in  1  serial data in; asynchronous.
- spi_miso_o  out  1  serial data out.
- spi_miso_oe_o  out  1  MISO output enable; high while selected.
- tx_data_i  in  DW  next word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  TX holding register is empty.
- rx_data_o  out  DW  last received word.
- rx_valid_o  out  1  rx_data_o holds an unread word.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- sel_o  out  1  synchronised chip-select-active status.
- tx_underrun_o  out  1  one-cycle pulse: DUMMY was loaded.
- rx_overrun_o  out  1  one-cycle pulse: a received word was dropped.
- abort_o  out  1  one-cycle pulse: CS_n rose mid-frame.

## Operation
- The SCK, CS_n and MOSI inputs each pass through a 2-flop synchroniser followed by an edge-detect register. SCK edges are classified as leading or trailing using CPOL.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the other one.
- TX holding register: loads on tx_valid_i && tx_ready_o; tx_ready_o is high when the register is empty.
- Word load into the TX shifter:
  - CPHA=0: at CS_n falling, and again at the shift edge after each DW-th sample while still selected.
  - CPHA=1: at the first leading edge of each word.
  - If the holding register is empty, DUMMY is loaded and tx_underrun_o pulses.
- MSB first by default. spi_miso_o presents the shifter's outgoing bit; the shifter advances on each shift edge.
- Sampling: on each sample edge, MOSI shifts into the RX shifter and the bit counter increments, wrapping at DW-1.
  - On the DW-th sample, the word transfers to rx_data_o and rx_valid_o rises.
  - If rx_valid_o is already high and rx_ready_i is low in that cycle, the new word is discarded, rx_data_o is unchanged and rx_overrun_o pulses.
  - Simultaneous rx_ready_i and a new word: the new word is accepted and rx_valid_o stays high.
- RX handshake: rx_valid_o falls on rx_valid_o && rx_ready_i.
- Back-to-back words within one CS_n assertion are continuous; there are no gap cycles.
- CS_n rising with the bit counter nonzero: the partial word is discarded, abort_o pulses, the counter clears, and a TX word already consumed into the shifter is lost.
- CS_n high: SCK edges are ignored, spi_miso_oe_o=0 and spi_miso_o=0.
- Reset values:
  - spi_miso_o=0, spi_miso_oe_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, sel_o=0, all pulse outputs 0.
  - Synchronisers reset to CS_n=1 and SCK=CPOL.
- Assertion of rst_i mid-frame returns all state to reset values; the master sees a truncated frame.

## Timing
- Pin-to-action latency: 3 clk_i cycles (2 synchroniser stages + edge detect).
- rx_valid_o rises 4 cycles after the DW-th sample edge at the pin.
- spi_miso_o updates 4 cycles after a shift edge at the pin, or after CS_n falls.
- Constraint: SCK high and low times ≥ 5 clk_i cycles each, i.e. f_clk ≥ 10·f_sck. CS_n setup to the first SCK edge ≥ 5 clk_i cycles.
- A TX word must be written ≥ 1 clk_i cycle before its load point to avoid underrun.

## Configuration
- MPEI_SPI_SLAVE_LSB_FIRST_EN:
  - Defined: both shifters operate LSB first (bit 0 on the wire first; the received first bit lands in bit 0).
  - Undefined: MSB first.
- The macro affects shift direction only; all handshake and timing behaviour is unchanged.

## Structure
- Shared package mpei_spi_pkg:
  - typedef spi_mode_t (CPOL/CPHA pair).
  - SPI_DW_DEFAULT constant.
  - SPI_SYNC_STAGES = 2.
  - The SPI controller uses the same package.
- One sub-module: mpei_sync2, a 2-flop synchroniser with a reset value parameter, instantiated three times.

## Test plan
- Mode 0, DW=8: master sends 0xA5 with TX preloaded 0x3C -> master receives 0x3C; rx_data_o=0xA5 with rx_valid_o high; no pulses.
- Three back-to-back words 0x01, 0x02, 0x03 with TX writes only before the first -> first word out = TX data; words 2 and 3 shift out 0xFF, and tx_underrun_o pulses twice.
- rx_ready_i held low across two words 0x11, 0x22 -> rx_data_o=0x11 and rx_overrun_o pulses once; after rx_ready_i, rx_valid_o=0.
- CS_n raised after 5 bits -> abort_o pulses once, rx_valid_o stays 0; the next full frame 0x5A is received correctly.
- CPOL=1, CPHA=1: master sends 0xC3 -> rx_data_o=0xC3; with MPEI_SPI_SLAVE_LSB_FIRST_EN defined, the wire order is LSB first and the same value is received.
- rst_i asserted at bit 4 -> all outputs at reset values in the same cycle; the subsequent frame completes normally.

Source files
------------

// File: rtl/mpei_spi_pkg.sv
// Shared SPI definitions for the MPEI RV MCU SPI controller and SPI target.
package mpei_spi_pkg;

  // SCK idle level and sampling phase of a link.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int unsigned SPI_DW_DEFAULT  = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

endpackage : mpei_spi_pkg

// File: rtl/mpei_spi_slave_if.sv
// SPI pins plus TX/RX valid-ready ports of the SPI target.
// slave modport: the target itself; master modport: the SPI master / register wrapper side.
interface mpei_spi_slave_if
  import mpei_spi_pkg::*;
#(
  parameter int unsigned DW = SPI_DW_DEFAULT
);

  logic          spi_sck_i;
  logic          spi_csn_i;
  logic          spi_mosi_i;
  logic          spi_miso_o;
  logic          spi_miso_oe_o;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          sel_o;
  logic          tx_underrun_o;
  logic          rx_overrun_o;
  logic          abort_o;

  modport slave (
    input  spi_sck_i, spi_csn_i, spi_mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    output spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           sel_o, tx_underrun_o, rx_overrun_o, abort_o
  );

  modport master (
    output spi_sck_i, spi_csn_i, spi_mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    input  spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           sel_o, tx_underrun_o, rx_overrun_o, abort_o
  );

endinterface : mpei_spi_slave_if

// File: rtl/mpei_sync2.sv
// Multi-flop synchroniser for one asynchronous input, with a configurable reset value.
module mpei_sync2
  import mpei_spi_pkg::*;
#(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  localparam int unsigned STAGES = SPI_SYNC_STAGES;

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= {STAGES{RST_VAL}};
    else       ff_q <= {ff_q[STAGES-2:0], d};
  end

  assign q = ff_q[STAGES-1];

endmodule : mpei_sync2

// File: rtl/mpei_spi_slave.sv
// SPI target: oversamples SCK/CS_n/MOSI in the clk_i domain, deserialises frames
// into a valid/ready RX port and serialises words from a one-deep TX holding register.
// Build option: define MPEI_SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB first.
module mpei_spi_slave
  import mpei_spi_pkg::*;
#(
  parameter int unsigned    DW    = SPI_DW_DEFAULT,
  parameter bit             CPOL  = 1'b0,
  parameter bit             CPHA  = 1'b0,
  parameter logic [DW-1:0]  DUMMY = '1
) (
  input logic             clk_i,
  input logic             rst_i,
  mpei_spi_slave_if.slave bus
);

  localparam int unsigned   CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam spi_mode_t     MODE = '{cpol: CPOL, cpha: CPHA};

`ifdef MPEI_SPI_SLAVE_LSB_FIRST_EN
  localparam int unsigned OUT_BIT = 0;
`else
  localparam int unsigned OUT_BIT = DW - 1;
`endif

  typedef enum logic {ST_IDLE, ST_SEL} state_t;

  // Synchronised pins
  logic sck_s, csn_s, mosi_s;

  // Edge-detect stage, aligned so MOSI/CS_n match the SCK edge they accompany
  logic sck_prev_q, lead_q, trail_q, mosi_q, csn_q;

  // Core state
  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic [DW-1:0] tx_hold_q, tx_hold_d;
  logic          tx_ready_q, tx_ready_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic          sel_q, sel_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
  logic          abort_q, abort_d;

  logic          active, sample_ev, shift_ev, load_ev;
  logic [DW-1:0] rx_next, tx_shifted;

  mpei_sync2 #(.RST_VAL(CPOL)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d(bus.spi_sck_i), .q(sck_s)
  );
  mpei_sync2 #(.RST_VAL(1'b1)) u_sync_csn (
    .clk_i(clk_i), .rst_i(rst_i), .d(bus.spi_csn_i), .q(csn_s)
  );
  mpei_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_i(rst_i), .d(bus.spi_mosi_i), .q(mosi_s)
  );

  // Classify SCK edges as leading/trailing and register the accompanying MOSI and CS_n.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_prev_q <= CPOL;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      mosi_q     <= 1'b0;
      csn_q      <= 1'b1;
    end else begin
      sck_prev_q <= sck_s;
      lead_q     <= (sck_s != sck_prev_q) && (sck_s != MODE.cpol);
      trail_q    <= (sck_s != sck_prev_q) && (sck_s == MODE.cpol);
      mosi_q     <= mosi_s;
      csn_q      <= csn_s;
    end
  end

  // Next-state logic: select tracking, TX load/shift, RX sample and handshakes.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
    load_ev    = 1'b0;

    active    = (state_q == ST_SEL) && !csn_q;
    sample_ev = active && (MODE.cpha ? trail_q : lead_q);
    shift_ev  = active && (MODE.cpha ? lead_q : trail_q);

`ifdef MPEI_SPI_SLAVE_LSB_FIRST_EN
    rx_next    = {mosi_q, rx_shift_q[DW-1:1]};
    tx_shifted = {1'b0, tx_shift_q[DW-1:1]};
`else
    rx_next    = {rx_shift_q[DW-2:0], mosi_q};
    tx_shifted = {tx_shift_q[DW-2:0], 1'b0};
`endif

    case (state_q)
      ST_IDLE: begin
        if (!csn_q) begin
          state_d = ST_SEL;
          load_ev = !MODE.cpha;
        end
      end
      ST_SEL: begin
        if (csn_q) begin
          state_d    = ST_IDLE;
          abort_d    = (bit_cnt_q != '0);
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (shift_ev) begin
          // A shift edge at a word boundary starts the next word instead of shifting.
          if (bit_cnt_q == '0) load_ev = 1'b1;
          else                 tx_shift_d = tx_shifted;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_ev) begin
      if (!tx_ready_q) begin
        tx_shift_d = tx_hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = DUMMY;
        underrun_d = 1'b1;
      end
    end

    if (bus.tx_valid_i && tx_ready_q) begin
      tx_hold_d  = bus.tx_data_i;
      tx_ready_d = 1'b0;
    end

    if (rx_valid_q && bus.rx_ready_i) rx_valid_d = 1'b0;

    if (sample_ev) begin
      rx_shift_d = rx_next;
      if (bit_cnt_q == LAST) begin
        bit_cnt_d = '0;
        if (rx_valid_q && !bus.rx_ready_i) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    oe_d   = (state_d == ST_SEL);
    sel_d  = oe_d;
    miso_d = oe_d ? tx_shift_d[OUT_BIT] : 1'b0;
  end

  // Core state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      sel_q      <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      sel_q      <= sel_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.spi_miso_o    = miso_q;
  assign bus.spi_miso_oe_o = oe_q;
  assign bus.tx_ready_o    = tx_ready_q;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.sel_o         = sel_q;
  assign bus.tx_underrun_o = underrun_q;
  assign bus.rx_overrun_o  = overrun_q;
  assign bus.abort_o       = abort_q;

endmodule : mpei_spi_slave

// File: tb/tb_mpei_spi_slave.sv
// Directed bench for mpei_spi_slave: a mode-0 instance and a mode-3 instance, each
// driven by a bit-banged SPI master running at 1/16 of clk.
module tb_mpei_spi_slave;

  localparam int HALF = 8;
`ifdef MPEI_SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  // Pulse counters, sampled away from the active edge.
  int und0 = 0, ovr0 = 0, abt0 = 0, abt3 = 0;

  always #5 clk = ~clk;

  mpei_spi_slave_if #(.DW(8)) b0 ();
  mpei_spi_slave_if #(.DW(8)) b3 ();

  mpei_spi_slave #(.DW(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(b0.slave)
  );
  mpei_spi_slave #(.DW(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk_i(clk), .rst_i(rst), .bus(b3.slave)
  );

  always @(negedge clk) begin
    if (b0.tx_underrun_o) und0 = und0 + 1;
    if (b0.rx_overrun_o)  ovr0 = ovr0 + 1;
    if (b0.abort_o)       abt0 = abt0 + 1;
    if (b3.abort_o)       abt3 = abt3 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, " miso"},     32'(b0.spi_miso_o),    32'h0);
    check({tag, " miso_oe"},  32'(b0.spi_miso_oe_o), 32'h0);
    check({tag, " tx_ready"}, 32'(b0.tx_ready_o),    32'h1);
    check({tag, " rx_valid"}, 32'(b0.rx_valid_o),    32'h0);
    check({tag, " rx_data"},  32'(b0.rx_data_o),     32'h0);
    check({tag, " sel"},      32'(b0.sel_o),         32'h0);
  endtask

  task automatic tx_write0(input logic [7:0] d);
    b0.tx_data_i  = d;
    b0.tx_valid_i = 1'b1;
    tick(1);
    b0.tx_valid_i = 1'b0;
  endtask

  // Mode 0: n bits, MOSI set in the low phase, MISO read just before the rising edge.
  // With close=0 SCK is left high so CS_n can be released before the closing edge.
  task automatic m0_bits(input logic [7:0] w, input int n, input bit close,
                         output logic [7:0] got);
    int idx;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      idx = LSB ? i : 7 - i;
      b0.spi_mosi_i = w[idx];
      tick(HALF);
      got[idx] = b0.spi_miso_o;
      b0.spi_sck_i = 1'b1;
      tick(HALF);
      if (close || i != n - 1) b0.spi_sck_i = 1'b0;
    end
  endtask

  task automatic cs_low0;
    b0.spi_csn_i = 1'b0;
    tick(HALF);
  endtask

  // Release CS_n while SCK is still high, then return SCK to idle while deselected.
  task automatic cs_high0;
    b0.spi_csn_i = 1'b1;
    tick(HALF);
    b0.spi_sck_i = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic consume0;
    b0.rx_ready_i = 1'b1;
    tick(1);
    b0.rx_ready_i = 1'b0;
    tick(1);
  endtask

  // Mode 3 full frame: SCK falls (leading, shift) then rises (trailing, sample).
  task automatic m3_frame(input logic [7:0] w, output logic [7:0] got);
    int idx;
    got = 8'h00;
    b3.spi_csn_i = 1'b0;
    tick(HALF);
    for (int i = 0; i < 8; i++) begin
      idx = LSB ? i : 7 - i;
      b3.spi_sck_i  = 1'b0;
      b3.spi_mosi_i = w[idx];
      tick(HALF);
      got[idx] = b3.spi_miso_o;
      b3.spi_sck_i = 1'b1;
      tick(HALF);
    end
    b3.spi_csn_i = 1'b1;
    tick(2 * HALF);
  endtask

  logic [7:0] got;
  int u_base, o_base, a_base;

  // Directed sequence.
  initial begin
    b0.spi_sck_i = 1'b0; b0.spi_csn_i = 1'b1; b0.spi_mosi_i = 1'b0;
    b0.tx_data_i = 8'h00; b0.tx_valid_i = 1'b0; b0.rx_ready_i = 1'b0;
    b3.spi_sck_i = 1'b1; b3.spi_csn_i = 1'b1; b3.spi_mosi_i = 1'b0;
    b3.tx_data_i = 8'h00; b3.tx_valid_i = 1'b0; b3.rx_ready_i = 1'b0;

    tick(3);
    check_reset0("reset");
    check("reset underrun", 32'(b0.tx_underrun_o), 32'h0);
    rst = 1'b0;
    tick(5);

    // Single frame 0xA5 against preloaded 0x3C.
    u_base = und0; o_base = ovr0; a_base = abt0;
    tx_write0(8'h3C);
    check("t1 tx_ready after write", 32'(b0.tx_ready_o), 32'h0);
    cs_low0();
    check("t1 sel", 32'(b0.sel_o), 32'h1);
    check("t1 miso_oe", 32'(b0.spi_miso_oe_o), 32'h1);
    m0_bits(8'hA5, 8, 1'b0, got);
    cs_high0();
    check("t1 master rx", 32'(got), 32'h3C);
    check("t1 rx_data", 32'(b0.rx_data_o), 32'hA5);
    check("t1 rx_valid", 32'(b0.rx_valid_o), 32'h1);
    check("t1 tx_ready after frame", 32'(b0.tx_ready_o), 32'h1);
    check("t1 underrun", 32'(und0 - u_base), 32'h0);
    check("t1 overrun", 32'(ovr0 - o_base), 32'h0);
    check("t1 abort", 32'(abt0 - a_base), 32'h0);
    check("t1 sel idle", 32'(b0.sel_o), 32'h0);
    check("t1 miso_oe idle", 32'(b0.spi_miso_oe_o), 32'h0);
    consume0();
    check("t1 rx_valid consumed", 32'(b0.rx_valid_o), 32'h0);

    // Three back-to-back words, only the first backed by TX data.
    u_base = und0;
    tx_write0(8'h81);
    b0.rx_ready_i = 1'b1;
    cs_low0();
    m0_bits(8'h01, 8, 1'b1, got);
    check("t2 master rx w1", 32'(got), 32'h81);
    check("t2 rx_data w1", 32'(b0.rx_data_o), 32'h01);
    m0_bits(8'h02, 8, 1'b1, got);
    check("t2 master rx w2", 32'(got), 32'hFF);
    check("t2 rx_data w2", 32'(b0.rx_data_o), 32'h02);
    m0_bits(8'h03, 8, 1'b0, got);
    check("t2 master rx w3", 32'(got), 32'hFF);
    cs_high0();
    check("t2 rx_data w3", 32'(b0.rx_data_o), 32'h03);
    check("t2 underrun", 32'(und0 - u_base), 32'h2);
    b0.rx_ready_i = 1'b0;
    tick(2);
    check("t2 rx_valid drained", 32'(b0.rx_valid_o), 32'h0);

    // Overrun: two words with the consumer stalled.
    o_base = ovr0;
    cs_low0();
    m0_bits(8'h11, 8, 1'b1, got);
    m0_bits(8'h22, 8, 1'b0, got);
    cs_high0();
    check("t3 rx_data", 32'(b0.rx_data_o), 32'h11);
    check("t3 rx_valid", 32'(b0.rx_valid_o), 32'h1);
    check("t3 overrun", 32'(ovr0 - o_base), 32'h1);
    consume0();
    check("t3 rx_valid consumed", 32'(b0.rx_valid_o), 32'h0);

    // Abort after 5 bits, then a clean frame.
    a_base = abt0;
    cs_low0();
    m0_bits(8'hF0, 5, 1'b0, got);
    cs_high0();
    check("t4 abort", 32'(abt0 - a_base), 32'h1);
    check("t4 rx_valid after abort", 32'(b0.rx_valid_o), 32'h0);
    cs_low0();
    m0_bits(8'h5A, 8, 1'b0, got);
    cs_high0();
    check("t4 rx_data", 32'(b0.rx_data_o), 32'h5A);
    check("t4 rx_valid", 32'(b0.rx_valid_o), 32'h1);
    check("t4 abort total", 32'(abt0 - a_base), 32'h1);
    consume0();

    // Mode 3 instance.
    b3.tx_data_i  = 8'h96;
    b3.tx_valid_i = 1'b1;
    tick(1);
    b3.tx_valid_i = 1'b0;
    m3_frame(8'hC3, got);
    check("t5 master rx", 32'(got), 32'h96);
    check("t5 rx_data", 32'(b3.rx_data_o), 32'hC3);
    check("t5 rx_valid", 32'(b3.rx_valid_o), 32'h1);
    check("t5 abort", 32'(abt3), 32'h0);

    // Reset in the middle of a frame (after 4 bits).
    tx_write0(8'h77);
    cs_low0();
    m0_bits(8'h99, 4, 1'b0, got);
    rst = 1'b1;
    #1;
    check_reset0("t6 mid-frame reset");
    b0.spi_csn_i = 1'b1;
    b0.spi_sck_i = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    a_base = abt0;
    tx_write0(8'hE1);
    cs_low0();
    m0_bits(8'h3C, 8, 1'b0, got);
    cs_high0();
    check("t6 master rx", 32'(got), 32'hE1);
    check("t6 rx_data", 32'(b0.rx_data_o), 32'h3C);
    check("t6 rx_valid", 32'(b0.rx_valid_o), 32'h1);
    check("t6 abort", 32'(abt0 - a_base), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_mpei_spi_slave
